// File: rtl/circuit_1_1.sv
// circuit_1_1: clocked three-input logic cell computing Z = A & (B xnor C).
// Provides the combinational result, a registered result with a valid flag,
// and a saturating count of captured results that were 1.
// CNT_W must be at least 1.

module circuit_1_1 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic             z_comb,
   output logic             z,
   output logic             out_valid,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Gate-level form of the reference circuit:
   // w1 = b ^ c, w2 = ~a, w3 = w1 & a, z = ~(w3 | w2), i.e. a & (b xnor c).
   logic w1;
   logic w2;
   logic w3;

   assign w1     = b ^ c;
   assign w2     = ~a;
   assign w3     = w1 & a;
   assign z_comb = ~(w3 | w2);

   // Capture the function value and flag it valid on qualified edges; z holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z         <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            z <= z_comb;
         end
      end
   end

   // Count captured ones, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt <= '0;
      end else if (in_valid && z_comb && (hit_cnt != CNT_MAX)) begin
         hit_cnt <= hit_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_circuit_1_1.sv
// tb_circuit_1_1: directed bench for circuit_1_1 with a behavioural model.
// Two instances share the stimulus: the default CNT_W=8 one and a CNT_W=2
// one that exposes counter saturation.

module tb_circuit_1_1;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       a;
   logic       b;
   logic       c;

   logic       z_comb8;
   logic       z8;
   logic       out_valid8;
   logic [7:0] hit_cnt8;

   logic       z_comb2;
   logic       z2;
   logic       out_valid2;
   logic [1:0] hit_cnt2;

   int checks;
   int failures;

   // Model state: truth table lookup plus integer counters.
   logic [7:0] truth;
   int         m_z;
   int         m_valid;
   int         m_hit8;
   int         m_hit2;

   circuit_1_1 #(.CNT_W(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c         (c),
      .z_comb    (z_comb8),
      .z         (z8),
      .out_valid (out_valid8),
      .hit_cnt   (hit_cnt8)
   );

   circuit_1_1 #(.CNT_W(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c         (c),
      .z_comb    (z_comb2),
      .z         (z2),
      .out_valid (out_valid2),
      .hit_cnt   (hit_cnt2)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int modelFunc(input logic fa, input logic fb, input logic fc);
      logic [2:0] idx;
      idx = {fa, fb, fc};
      return int'(truth[idx]);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks = checks + 1;
      if (actual != expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Drive one input vector, let it be captured, and return 1 unit after the edge.
   task automatic applyStimulus(input logic v, input logic [2:0] abc);
      in_valid = v;
      a = abc[2];
      b = abc[1];
      c = abc[0];
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: capture on qualified edges, clear at once on reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_z     = 0;
         m_valid = 0;
         m_hit8  = 0;
         m_hit2  = 0;
      end else begin
         m_valid = in_valid ? 1 : 0;
         if (in_valid) begin
            m_z = modelFunc(a, b, c);
            if (m_z == 1) begin
               if (m_hit8 < 255) m_hit8 = m_hit8 + 1;
               if (m_hit2 < 3)   m_hit2 = m_hit2 + 1;
            end
         end
      end
   end

   // Compare every output of both instances against the model on each falling edge.
   always @(negedge clk) begin
      checkOutput("z_comb8",    int'(z_comb8),    modelFunc(a, b, c));
      checkOutput("z_comb2",    int'(z_comb2),    modelFunc(a, b, c));
      checkOutput("z8",         int'(z8),         m_z);
      checkOutput("z2",         int'(z2),         m_z);
      checkOutput("out_valid8", int'(out_valid8), m_valid);
      checkOutput("out_valid2", int'(out_valid2), m_valid);
      checkOutput("hit_cnt8",   int'(hit_cnt8),   m_hit8);
      checkOutput("hit_cnt2",   int'(hit_cnt2),   m_hit2);
   end

   // Directed sequence with literal expectations.
   initial begin
      logic [7:0] exp_z;
      logic [2:0] v;
      int         sat_seq [5];

      truth    = 8'b1001_0000;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a = 1'b0;
      b = 1'b0;
      c = 1'b0;

      // Step 1: in reset, outputs zero, z_comb follows the table.
      exp_z = 8'b1001_0000;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         a = v[2];
         b = v[1];
         c = v[0];
         in_valid = 1'b1;
         #3;
         checkOutput("rst_z_comb", int'(z_comb8), int'(exp_z[i]));
         checkOutput("rst_z",      int'(z8),         0);
         checkOutput("rst_valid",  int'(out_valid8), 0);
         checkOutput("rst_hit",    int'(hit_cnt8),   0);
      end

      // Release reset between edges.
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Step 2: all eight combinations.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'(i));
         checkOutput("seq_z",     int'(z8),         int'(exp_z[i]));
         checkOutput("seq_valid", int'(out_valid8), 1);
      end
      checkOutput("seq_hit8", int'(hit_cnt8), 2);
      checkOutput("seq_hit2", int'(hit_cnt2), 2);

      // Step 3: idle with abc=100, z holds, valid drops, count holds.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 3'b100);
         checkOutput("idle_valid",  int'(out_valid8), 0);
         checkOutput("idle_z",      int'(z8),         1);
         checkOutput("idle_hit",    int'(hit_cnt8),   2);
         checkOutput("idle_z_comb", int'(z_comb8),    1);
      end

      // Step 5: asynchronous reset mid-stream with z=1, hit_cnt=2.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_z",     int'(z8),         0);
      checkOutput("async_valid", int'(out_valid8), 0);
      checkOutput("async_hit",   int'(hit_cnt8),   0);
      checkOutput("async_hit2",  int'(hit_cnt2),   0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Step 4: saturation on the narrow counter.
      sat_seq = '{1, 2, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 3'b111);
         checkOutput("sat_hit2", int'(hit_cnt2), sat_seq[i]);
         checkOutput("sat_hit8", int'(hit_cnt8), i + 1);
      end

      // Step 6: non-matching vectors leave the counters alone.
      applyStimulus(1'b1, 3'b101);
      checkOutput("miss1_z",    int'(z8),       0);
      checkOutput("miss1_hit8", int'(hit_cnt8), 5);
      applyStimulus(1'b1, 3'b110);
      checkOutput("miss2_z",    int'(z8),       0);
      checkOutput("miss2_hit8", int'(hit_cnt8), 5);
      checkOutput("miss2_hit2", int'(hit_cnt2), 3);

      applyStimulus(1'b0, 3'b000);
      @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
